// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: word width, default
// instruction width and the fetch FSM state encodings.
package fetch_unit_pkg;

  localparam int WORD            = 64;
  localparam int INSTR_W_DEFAULT = 32;

  typedef logic [WORD-1:0] word_t;

  localparam logic [1:0] FS_REQ   = 2'd0;
  localparam logic [1:0] FS_WAIT  = 2'd1;
  localparam logic [1:0] FS_HOLD  = 2'd2;
  localparam logic [1:0] FS_DRAIN = 2'd3;

  // Branch targets are word aligned; the two low bits are dropped, not trapped.
  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter: reset value, sequential +4 advance and redirect load.
module fetch_unit_pc_register
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = '0
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  redirect,
  input  word_t target,
  input  logic  advance,
  output word_t pc
);

  // Redirect wins over the sequential advance when both occur in one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_word(target);
    end else if (advance) begin
      pc <= pc + word_t'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, registered
// instruction/PC hand-off to decode, redirect with in-flight discard.
//
// state    | meaning
// ---------+--------------------------------------------------------
// FS_REQ   | presenting a request for pc to instruction memory
// FS_WAIT  | request accepted, waiting for its response
// FS_HOLD  | instruction presented to decode, waiting for if_ready
// FS_DRAIN | redirected while a request was outstanding; discard it
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = '0,
  parameter int    INSTR_W  = INSTR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pc_src,
  input  word_t              branch_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output word_t              imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output word_t              if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  word_t      pc;
  logic       accept;
  logic       capture;
  logic       drop;

  fetch_unit_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .redirect (pc_src),
    .target   (branch_target),
    .advance  (capture),
    .pc       (pc)
  );

  // Gated by reset_n so no request is offered while reset is held.
  assign imem_req_valid = reset_n && (state == FS_REQ);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      FS_REQ: begin
        if (pc_src) begin
          state_nxt = accept ? FS_DRAIN : FS_REQ;
        end else if (accept) begin
          state_nxt = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (pc_src) begin
          state_nxt = FS_DRAIN;
        end else if (imem_resp_valid) begin
          state_nxt = FS_HOLD;
          capture   = 1'b1;
        end
      end
      FS_HOLD: begin
        // A redirect drops the held instruction even if decode takes it.
        if (pc_src || if_ready) begin
          state_nxt = FS_REQ;
          drop      = 1'b1;
        end
      end
      FS_DRAIN: begin
        if (!pc_src && imem_resp_valid) begin
          state_nxt = FS_REQ;
        end
      end
      default: state_nxt = FS_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FS_REQ;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_instr <= imem_resp_data;
      end else if (drop) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory plus a
// scoreboard of instructions expected to be accepted by decode.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    word_t       pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        pc_src;
  word_t       branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  word_t       imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  word_t       if_pc;
  logic [31:0] if_instr;

  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_lat  = 1;
  exp_t sb[$];

  fetch_unit #(
    .RESET_PC ('0),
    .INSTR_W  (32)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc_src          (pc_src),
    .branch_target   (branch_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input word_t a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0001;
  endfunction

  function automatic void push_exp(input word_t a);
    exp_t e;
    e.pc    = a;
    e.instr = instr_of(a);
    sb.push_back(e);
  endfunction

  // Instruction memory: responds mem_lat cycles after acceptance; reset abandons.
  initial begin : imem_model
    logic  acc_now;
    word_t acc_addr;
    word_t pend_addr;
    int    cnt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    pend_addr       = '0;
    cnt             = 0;
    forever begin
      @(negedge clk);
      acc_now  = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #2;
      imem_resp_valid = 1'b0;
      if (!reset_n) begin
        cnt     = 0;
        acc_now = 1'b0;
      end
      if (acc_now) begin
        cnt       = mem_lat;
        pend_addr = acc_addr;
      end
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = instr_of(pend_addr);
        end
      end
    end
  end

  // Decode-side monitor: a handshake counts only when no redirect is present.
  initial begin : decode_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && if_valid && if_ready && !pc_src) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_accept pc=%h instr=%h (no instruction expected)", if_pc, if_instr);
        end else begin
          e = sb.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            n_errors++;
            $display("FAIL accepted_instr got pc=%h instr=%h expected pc=%h instr=%h",
                     if_pc, if_instr, e.pc, e.instr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    pc_src         = 1'b0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    branch_target  = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Ends at the negedge where if_valid is seen, or reports a timeout.
  task automatic wait_if_valid(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_valid) return;
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s_timeout if_valid=%b expected 1 within 40 cycles", nm, if_valid);
  endtask

  task automatic wait_req_valid(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid) return;
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s_timeout imem_req_valid=%b expected 1 within 40 cycles", nm, imem_req_valid);
  endtask

  task automatic wait_req_addr(input word_t a, input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_addr === a) return;
      step();
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s_timeout addr=%h expected request for %h", nm, imem_req_addr, a);
  endtask

  // Ends at a drive point with the scoreboard empty, or reports a timeout.
  task automatic wait_drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      step();
      if (sb.size() == 0) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s_drain pending=%0d expected 0", nm, sb.size());
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid got %b expected 0", imem_req_valid); end
    n_checks++;
    if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid got %b expected 0", if_valid); end
    n_checks++;
    if (if_pc !== '0) begin n_errors++; $display("FAIL reset_if_pc got %h expected 0", if_pc); end
    n_checks++;
    if (if_instr !== '0) begin n_errors++; $display("FAIL reset_if_instr got %h expected 0", if_instr); end
    n_checks++;
    if (imem_req_addr !== '0) begin n_errors++; $display("FAIL reset_addr got %h expected 0", imem_req_addr); end
    step();
  endtask

  task automatic test_sequential();
    int pulses[$];
    do_reset();
    mem_lat  = 1;
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(word_t'(4 * k));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
          n_errors++;
          $display("FAIL first_req got valid=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr);
        end
      end
      if (if_valid) pulses.push_back(i);
      step();
    end
    if_ready = 1'b0;
    n_checks++;
    if (pulses.size() != 4) begin
      n_errors++;
      $display("FAIL pulse_count got %0d expected 4", pulses.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (pulses[k] - pulses[k-1] != 3) begin
          n_errors++;
          $display("FAIL pulse_gap got %0d expected 3", pulses[k] - pulses[k-1]);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin n_errors++; $display("FAIL seq_pending got %0d expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    word_t       hold_pc;
    logic [31:0] hold_instr;
    wait_if_valid("bp_hold");
    hold_pc    = if_pc;
    hold_instr = if_instr;
    n_checks++;
    if (if_pc !== word_t'(16) || if_instr !== instr_of(word_t'(16))) begin
      n_errors++;
      $display("FAIL bp_first got pc=%h instr=%h expected pc=10", if_pc, if_instr);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== hold_pc || if_instr !== hold_instr || imem_req_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_stable got v=%b pc=%h instr=%h req=%b expected 1/%h/%h/0",
                 if_valid, if_pc, if_instr, imem_req_valid, hold_pc, hold_instr);
      end
    end
    step();
    push_exp(word_t'(16));
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== word_t'(20)) begin
      n_errors++;
      $display("FAIL bp_next_req got valid=%b addr=%h expected 1/14", imem_req_valid, imem_req_addr);
    end
    step();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat  = 3;
    if_ready = 1'b1;
    push_exp(word_t'(0));
    push_exp(word_t'(4));
    wait_req_addr(word_t'(8), "rw_req8");
    step();
    pc_src        = 1'b1;
    branch_target = word_t'(64'h100);
    step();
    pc_src = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== word_t'(64'h100)) begin
      n_errors++;
      $display("FAIL rw_drain got valid=%b addr=%h expected 0/100", imem_req_valid, imem_req_addr);
    end
    push_exp(word_t'(64'h100));
    step();
    wait_req_valid("rw_newreq");
    n_checks++;
    if (imem_req_addr !== word_t'(64'h100)) begin
      n_errors++;
      $display("FAIL rw_newreq_addr got %h expected 100", imem_req_addr);
    end
    step();
    wait_drain("rw");
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_hold();
    do_reset();
    mem_lat  = 1;
    push_exp(word_t'(0));
    wait_if_valid("rh_first");
    step();
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    wait_if_valid("rh_second");
    n_checks++;
    if (if_pc !== word_t'(4)) begin n_errors++; $display("FAIL rh_held_pc got %h expected 4", if_pc); end
    step();
    pc_src        = 1'b1;
    branch_target = word_t'(64'h300);
    if_ready      = 1'b1;
    step();
    pc_src   = 1'b0;
    if_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== word_t'(64'h300)) begin
      n_errors++;
      $display("FAIL rh_after got v=%b req=%b addr=%h expected 0/1/300", if_valid, imem_req_valid, imem_req_addr);
    end
    step();
    push_exp(word_t'(64'h300));
    if_ready = 1'b1;
    wait_drain("rh");
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_accept();
    do_reset();
    mem_lat       = 2;
    pc_src        = 1'b1;
    branch_target = word_t'(64'h203);
    step();
    pc_src = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== word_t'(64'h200)) begin
      n_errors++;
      $display("FAIL ra_drain got valid=%b addr=%h expected 0/200", imem_req_valid, imem_req_addr);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL ra_drain2 got valid=%b expected 0", imem_req_valid); end
    step();
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== word_t'(64'h200)) begin
      n_errors++;
      $display("FAIL ra_newreq got valid=%b addr=%h expected 1/200", imem_req_valid, imem_req_addr);
    end
    push_exp(word_t'(64'h200));
    step();
    if_ready = 1'b1;
    wait_drain("ra");
    if_ready = 1'b0;
  endtask

  task automatic test_wrap();
    word_t top;
    top = '1;
    top[1:0] = 2'b00;
    do_reset();
    mem_lat        = 1;
    imem_req_ready = 1'b0;
    pc_src         = 1'b1;
    branch_target  = '1;
    step();
    pc_src = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== top) begin
      n_errors++;
      $display("FAIL wrap_req got valid=%b addr=%h expected 1/%h", imem_req_valid, imem_req_addr, top);
    end
    step();
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    push_exp(top);
    wait_drain("wrap");
    if_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
      n_errors++;
      $display("FAIL wrap_next got valid=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    mem_lat  = 4;
    if_ready = 1'b1;
    push_exp(word_t'(0));
    push_exp(word_t'(4));
    wait_req_addr(word_t'(8), "rst_req8");
    step();
    reset_n = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0 || imem_req_valid !== 1'b0 || imem_req_addr !== '0) begin
      n_errors++;
      $display("FAIL rst_wait got v=%b pc=%h instr=%h req=%b addr=%h expected 0/0/0/0/0",
               if_valid, if_pc, if_instr, imem_req_valid, imem_req_addr);
    end
    step();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== '0) begin
      n_errors++;
      $display("FAIL rst_newreq got valid=%b addr=%h expected 1/0", imem_req_valid, imem_req_addr);
    end
    push_exp(word_t'(0));
    step();
    wait_drain("rst");
    if_ready = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    pc_src         = 1'b0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    branch_target  = '0;
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_accept();
    test_wrap();
    test_reset_in_wait();
    n_checks++;
    if (sb.size() != 0) begin n_errors++; $display("FAIL final_pending got %0d expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
